// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transaction arbiter: FSM state encoding,
// chunk descriptor struct and the round-robin pointer helper.
package hyperbus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } hyperbus_state_e;

   // Field widths are sized for the largest supported configuration.
   localparam int HB_CS_MAX_W    = 8;
   localparam int HB_BURST_MAX_W = 16;

   typedef struct packed {
      logic [31:0]               address;
      logic [HB_CS_MAX_W-1:0]    cs;
      logic                      write;
      logic [HB_BURST_MAX_W-1:0] burst;
   } hyperbus_trans_t;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i
// (wrapping) wins; grant is one-hot, or zero when nothing is requested.
module hyperbus_rr_arbiter #(
   parameter int NR_REQ = 2
) (
   input  logic [NR_REQ-1:0]         req_i,
   input  logic [$clog2(NR_REQ)-1:0] ptr_i,
   output logic [NR_REQ-1:0]         grant_o,
   output logic [$clog2(NR_REQ)-1:0] idx_o,
   output logic                      valid_o
);

   localparam int IDX_W = $clog2(NR_REQ);

   logic [IDX_W-1:0] pos;

   // Scan from the farthest offset down so the closest requester is written last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = '0;
      for (int off = NR_REQ - 1; off >= 0; off--) begin
         pos = IDX_W'((int'(ptr_i) + off) % NR_REQ);
         if (req_i[pos]) begin
            grant_o      = '0;
            grant_o[pos] = 1'b1;
            idx_o        = pos;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter feeding one HyperBus PHY; define HYPERBUS_ARB_SPLIT_EN
// to cut long bursts into MAX_BURST-word chunks, otherwise a burst goes out whole.
module hyperbus_trans_arbiter
   import hyperbus_pkg::*;
#(
   parameter int NR_REQ      = 2,
   parameter int NR_CS       = 2,
   parameter int BURST_WIDTH = 12,
   parameter int MAX_BURST   = 256
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NR_REQ-1:0]                   req_valid_i,
   output logic [NR_REQ-1:0]                   req_ready_o,
   input  logic [NR_REQ-1:0][31:0]             req_address_i,
   input  logic [NR_REQ-1:0][NR_CS-1:0]        req_cs_i,
   input  logic [NR_REQ-1:0]                   req_write_i,
   input  logic [NR_REQ-1:0][BURST_WIDTH-1:0]  req_burst_i,
   output logic                                trans_valid_o,
   input  logic                                trans_ready_i,
   output logic [31:0]                         trans_address_o,
   output logic [NR_CS-1:0]                    trans_cs_o,
   output logic                                trans_write_o,
   output logic [BURST_WIDTH-1:0]              trans_burst_o,
   input  logic                                trans_done_i,
   output logic                                grant_valid_o,
   output logic [$clog2(NR_REQ)-1:0]           grant_id_o
);

   localparam int ID_W = $clog2(NR_REQ);

   hyperbus_state_e  state_reg, state_next;
   logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [ID_W-1:0]  grant_id_reg, grant_id_next;
   logic             grant_valid_reg, grant_valid_next;
   hyperbus_trans_t  desc_reg, desc_next;

   logic [NR_REQ-1:0]      win_grant;
   logic [ID_W-1:0]        win_idx;
   logic                   win_valid;
   logic [BURST_WIDTH-1:0] remaining;
   logic [BURST_WIDTH-1:0] chunk;

   hyperbus_rr_arbiter #(
      .NR_REQ (NR_REQ)
   ) u_rr_arbiter (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_reg),
      .grant_o (win_grant),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   // desc_reg.burst tracks the words still owed to the current owner.
   assign remaining = desc_reg.burst[BURST_WIDTH-1:0];

`ifdef HYPERBUS_ARB_SPLIT_EN
   localparam logic [BURST_WIDTH-1:0] MAX_CHUNK = BURST_WIDTH'(MAX_BURST);
   assign chunk = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
`else
   assign chunk = remaining;
`endif

   always_comb begin
      state_next       = state_reg;
      rr_ptr_next      = rr_ptr_reg;
      grant_id_next    = grant_id_reg;
      grant_valid_next = grant_valid_reg;
      desc_next        = desc_reg;
      case (state_reg)
         IDLE: begin
            if (win_valid) begin
               if (req_burst_i[win_idx] == '0) begin
                  // Empty burst: retire on accept, never touch the PHY.
                  rr_ptr_next = ID_W'(rr_next(int'(win_idx), NR_REQ));
               end else begin
                  desc_next.address = req_address_i[win_idx];
                  desc_next.cs      = HB_CS_MAX_W'(req_cs_i[win_idx]);
                  desc_next.write   = req_write_i[win_idx];
                  desc_next.burst   = HB_BURST_MAX_W'(req_burst_i[win_idx]);
                  grant_id_next     = win_idx;
                  grant_valid_next  = 1'b1;
                  state_next        = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (trans_ready_i) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (trans_done_i) begin
               desc_next.burst   = HB_BURST_MAX_W'(remaining - chunk);
               desc_next.address = desc_reg.address + 32'({chunk, 1'b0});
               if (remaining == chunk) begin
                  state_next       = IDLE;
                  grant_valid_next = 1'b0;
                  rr_ptr_next      = ID_W'(rr_next(int'(grant_id_reg), NR_REQ));
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg       <= IDLE;
         rr_ptr_reg      <= '0;
         grant_id_reg    <= '0;
         grant_valid_reg <= 1'b0;
         desc_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         rr_ptr_reg      <= rr_ptr_next;
         grant_id_reg    <= grant_id_next;
         grant_valid_reg <= grant_valid_next;
         desc_reg        <= desc_next;
      end
   end

   assign req_ready_o     = (state_reg == IDLE) ? win_grant : '0;
   assign trans_valid_o   = (state_reg == ISSUE);
   assign trans_address_o = desc_reg.address;
   assign trans_cs_o      = desc_reg.cs[NR_CS-1:0];
   assign trans_write_o   = desc_reg.write;
   assign trans_burst_o   = chunk;
   assign grant_valid_o   = grant_valid_reg;
   assign grant_id_o      = grant_id_reg;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Scoreboard bench for hyperbus_trans_arbiter: expected accepts and PHY
// transactions are queued by the stimulus and popped by a negedge monitor.
module tb_hyperbus_trans_arbiter;

   localparam int NR_REQ = 2;
   localparam int NR_CS  = 2;
   localparam int BW     = 12;
   localparam int MAXB   = 256;

   logic                          clk_i = 1'b0;
   logic                          rst_i = 1'b1;
   logic [NR_REQ-1:0]             req_valid_i = '0;
   logic [NR_REQ-1:0]             req_ready_o;
   logic [NR_REQ-1:0][31:0]       req_address_i = '0;
   logic [NR_REQ-1:0][NR_CS-1:0]  req_cs_i = '0;
   logic [NR_REQ-1:0]             req_write_i = '0;
   logic [NR_REQ-1:0][BW-1:0]     req_burst_i = '0;
   logic                          trans_valid_o;
   logic                          trans_ready_i = 1'b0;
   logic [31:0]                   trans_address_o;
   logic [NR_CS-1:0]              trans_cs_o;
   logic                          trans_write_o;
   logic [BW-1:0]                 trans_burst_o;
   logic                          trans_done_i = 1'b0;
   logic                          grant_valid_o;
   logic [0:0]                    grant_id_o;

   typedef struct {
      logic [31:0]      addr;
      logic [BW-1:0]    burst;
      logic [NR_CS-1:0] cs;
      logic             wr;
      int               gid;
   } exp_t;

   exp_t exp_trans[$];
   int   exp_acc[$];
   int   checks = 0;
   int   errors = 0;
   logic [NR_REQ-1:0] ready_seen = '0;

   hyperbus_trans_arbiter #(
      .NR_REQ      (NR_REQ),
      .NR_CS       (NR_CS),
      .BURST_WIDTH (BW),
      .MAX_BURST   (MAXB)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_address_i   (req_address_i),
      .req_cs_i        (req_cs_i),
      .req_write_i     (req_write_i),
      .req_burst_i     (req_burst_i),
      .trans_valid_o   (trans_valid_o),
      .trans_ready_i   (trans_ready_i),
      .trans_address_o (trans_address_o),
      .trans_cs_o      (trans_cs_o),
      .trans_write_o   (trans_write_o),
      .trans_burst_o   (trans_burst_o),
      .trans_done_i    (trans_done_i),
      .grant_valid_o   (grant_valid_o),
      .grant_id_o      (grant_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: compares every accept and every PHY handshake against the queues.
   always @(negedge clk_i) begin
      exp_t e;
      int   idx;
      ready_seen = rst_i ? '0 : req_ready_o;
      if (!rst_i) begin
         if (req_ready_o != '0) begin
            if (exp_acc.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL accept_unexpected actual=%0b required=none", req_ready_o);
            end else begin
               idx = exp_acc.pop_front();
               check("accept_onehot", 32'(req_ready_o), 32'(1) << idx);
               $display("ACCEPT req=%0d ready=%0b", idx, req_ready_o);
            end
         end
         if (trans_valid_o && trans_ready_i) begin
            if (exp_trans.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL trans_unexpected actual=addr %0h burst %0d required=none",
                        trans_address_o, trans_burst_o);
            end else begin
               e = exp_trans.pop_front();
               check("trans_addr", trans_address_o, e.addr);
               check("trans_burst", 32'(trans_burst_o), 32'(e.burst));
               check("trans_cs", 32'(trans_cs_o), 32'(e.cs));
               check("trans_write", 32'(trans_write_o), 32'(e.wr));
               check("grant_id", 32'(grant_id_o), 32'(e.gid));
               check("grant_valid", 32'(grant_valid_o), 32'd1);
               $display("TRANS addr=%08h burst=%0d cs=%0b wr=%0b gid=%0d",
                        trans_address_o, trans_burst_o, trans_cs_o, trans_write_o, grant_id_o);
            end
         end
      end
   end

   // Requester model: drop valid once the accept has been seen.
   always @(posedge clk_i) begin
      #1;
      for (int i = 0; i < NR_REQ; i++) begin
         if (ready_seen[i]) req_valid_i[i] = 1'b0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input int idx, input logic [31:0] addr, input logic [NR_CS-1:0] cs,
                        input logic wr, input logic [BW-1:0] burst);
      req_address_i[idx] = addr;
      req_cs_i[idx]      = cs;
      req_write_i[idx]   = wr;
      req_burst_i[idx]   = burst;
      req_valid_i[idx]   = 1'b1;
      exp_acc.push_back(idx);
   endtask

   task automatic expect_trans(input logic [31:0] addr, input logic [BW-1:0] burst,
                               input logic [NR_CS-1:0] cs, input logic wr, input int gid);
      exp_t e;
      e.addr = addr; e.burst = burst; e.cs = cs; e.wr = wr; e.gid = gid;
      exp_trans.push_back(e);
   endtask

   task automatic phy_handshake();
      int n = 0;
      while (!trans_valid_o && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!trans_valid_o) begin
         errors++;
         $display("FAIL trans_valid_timeout actual=0 required=1");
      end else begin
         trans_ready_i = 1'b1;
         tick();
         trans_ready_i = 1'b0;
      end
   endtask

   task automatic phy_done();
      tick(2);
      trans_done_i = 1'b1;
      tick();
      trans_done_i = 1'b0;
   endtask

   task automatic phy_serve(input int chunks);
      for (int c = 0; c < chunks; c++) begin
         phy_handshake();
         phy_done();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready_o), 32'd0);
      check({tag, "_trans_valid"}, 32'(trans_valid_o), 32'd0);
      check({tag, "_grant_valid"}, 32'(grant_valid_o), 32'd0);
      check({tag, "_grant_id"}, 32'(grant_id_o), 32'd0);
      check({tag, "_addr"}, trans_address_o, 32'd0);
      check({tag, "_cs"}, 32'(trans_cs_o), 32'd0);
      check({tag, "_write"}, 32'(trans_write_o), 32'd0);
      check({tag, "_burst"}, 32'(trans_burst_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_chunks;
`ifdef HYPERBUS_ARB_SPLIT_EN
      n_chunks = 3;
`else
      n_chunks = 1;
`endif
      // Reset state
      tick(2);
      check_all_zero("reset");
      rst_i = 1'b0;
      tick();

      // Single requester, burst 16 at 0x100; ready is combinational, trans_valid one cycle later
      issue(0, 32'h100, 2'b01, 1'b1, 12'd16);
      expect_trans(32'h100, 12'd16, 2'b01, 1'b1, 0);
      #1;
      check("s1_ready_comb", 32'(req_ready_o), 32'b01);
      check("s1_no_valid_yet", 32'(trans_valid_o), 32'd0);
      tick();
      check("s1_latency", 32'(trans_valid_o), 32'd1);
      check("s1_grant_valid", 32'(grant_valid_o), 32'd1);
      phy_serve(1);
      check("s1_idle_grant", 32'(grant_valid_o), 32'd0);
      check("s1_idle_valid", 32'(trans_valid_o), 32'd0);

      // Burst 0 on req1 with rr_ptr at 1: accepted once, no PHY traffic, pointer wraps to 0
      issue(1, 32'h300, 2'b10, 1'b0, 12'd0);
      #1;
      check("b0_ready", 32'(req_ready_o), 32'b10);
      tick();
      #1;
      check("b0_no_trans", 32'(trans_valid_o), 32'd0);
      check("b0_no_grant", 32'(grant_valid_o), 32'd0);
      tick(2);
      check("b0_still_no_trans", 32'(trans_valid_o), 32'd0);

      // Both requesters at once with rr_ptr 0: req0 first, then req1
      issue(0, 32'h1000, 2'b01, 1'b0, 12'd4);
      issue(1, 32'h2000, 2'b10, 1'b1, 12'd8);
      expect_trans(32'h1000, 12'd4, 2'b01, 1'b0, 0);
      expect_trans(32'h2000, 12'd8, 2'b10, 1'b1, 1);
      phy_serve(2);
      check("s2_idle_grant", 32'(grant_valid_o), 32'd0);

      // rr_ptr back at 0: req0 wins again, then req1's 600-word burst
      issue(0, 32'h4000, 2'b01, 1'b1, 12'd2);
      issue(1, 32'h0, 2'b10, 1'b0, 12'd600);
      expect_trans(32'h4000, 12'd2, 2'b01, 1'b1, 0);
`ifdef HYPERBUS_ARB_SPLIT_EN
      expect_trans(32'h0,   12'd256, 2'b10, 1'b0, 1);
      expect_trans(32'h200, 12'd256, 2'b10, 1'b0, 1);
      expect_trans(32'h400, 12'd88,  2'b10, 1'b0, 1);
`else
      expect_trans(32'h0, 12'd600, 2'b10, 1'b0, 1);
`endif
      phy_serve(1);
      phy_serve(n_chunks);
      check("s3_idle_grant", 32'(grant_valid_o), 32'd0);
      check("s3_idle_valid", 32'(trans_valid_o), 32'd0);

      // Reset while BUSY (second chunk when splitting); late trans_done is ignored
`ifdef HYPERBUS_ARB_SPLIT_EN
      issue(0, 32'h8000, 2'b01, 1'b0, 12'd600);
      expect_trans(32'h8000, 12'd256, 2'b01, 1'b0, 0);
      expect_trans(32'h8200, 12'd256, 2'b01, 1'b0, 0);
      phy_serve(1);
      phy_handshake();
`else
      issue(0, 32'h8000, 2'b01, 1'b0, 12'd40);
      expect_trans(32'h8000, 12'd40, 2'b01, 1'b0, 0);
      phy_handshake();
`endif
      tick();
      check("rst_pre_grant", 32'(grant_valid_o), 32'd1);
      rst_i = 1'b1;
      tick();
      check_all_zero("midrst");
      rst_i = 1'b0;
      trans_done_i = 1'b1;
      tick();
      trans_done_i = 1'b0;
      tick(3);
      check("post_rst_valid", 32'(trans_valid_o), 32'd0);
      check("post_rst_grant", 32'(grant_valid_o), 32'd0);
      check("post_rst_addr", trans_address_o, 32'd0);
      check("post_rst_burst", 32'(trans_burst_o), 32'd0);

      check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
      check("trans_queue_empty", 32'(exp_trans.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
